// File: rtl/calc_spi_pkg.sv
// Shared constants and types for the calculator SPI register front end.
// Frame layout is {rw, addr, data}, shifted MSB first.
package calc_spi_pkg;

    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int RW_BIT  = FRAME_W - 1;
    localparam int HDR_W   = 1 + ADDR_W;
    localparam int CNT_W   = 5;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        WDATA,
        RDATA,
        WAIT_CS
    } rx_state_t;

    localparam logic [DATA_W-1:0] OP_ADD = 8'h10;
    localparam logic [DATA_W-1:0] OP_SUB = 8'h20;
    localparam logic [DATA_W-1:0] OP_EQ  = 8'h30;

    function automatic logic [ADDR_W-1:0] frame_addr(
        input logic [FRAME_W-1:0] f
    );
        return f[RW_BIT-1 -: ADDR_W];
    endfunction

    function automatic logic [DATA_W-1:0] frame_data(
        input logic [FRAME_W-1:0] f
    );
        return f[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser plus a history flop for one asynchronous pin.
// Edge strobes compare the synchronised level against its previous value.
module spi_pin_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync_a;
    logic sync_b;
    logic hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= RST_VAL;
            sync_b <= RST_VAL;
            hist   <= RST_VAL;
        end else begin
            sync_a <= pin;
            sync_b <= sync_a;
            hist   <= sync_b;
        end
    end

    assign level = sync_b;
    assign rise  = sync_b & ~hist;
    assign fall  = ~sync_b & hist;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 slave that turns 16-bit frames into calculator register
// writes and reads, all logic running in the oversampling clk domain.
module spi_frame_rx
    import calc_spi_pkg::*;
#(
    parameter int WR_PULSE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_w,
    output logic              write_vld,
    output logic              read_en,
    input  logic [DATA_W-1:0] data_r,
    output logic              frame_err
);

    localparam int PW = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;

    logic sclk_lvl;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_lvl;
    logic cs_rise;
    logic cs_fall;
    logic mosi_lvl;
    logic mosi_rise;
    logic mosi_fall;
    logic unused_edges;

    spi_pin_sync #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (spi_sclk),
        .level (sclk_lvl),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // cs_n idles high so a reset never looks like a select edge
    spi_pin_sync #(.RST_VAL(1'b1)) u_cs_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (spi_cs_n),
        .level (cs_lvl),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_pin_sync #(.RST_VAL(1'b0)) u_mosi_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (spi_mosi),
        .level (mosi_lvl),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    assign unused_edges = ^{sclk_lvl, cs_rise, mosi_rise, mosi_fall};

    rx_state_t          state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] rx_sreg;
    logic [DATA_W-1:0]  tx_sreg;
    logic [PW-1:0]      wr_cnt;

    logic [FRAME_W-1:0] rx_next;
    logic               hdr_rise;
    logic               last_rise;
    logic               extra_rise;
    logic               active;

    assign rx_next    = {rx_sreg[FRAME_W-2:0], mosi_lvl};
    assign hdr_rise   = sclk_rise && (bit_cnt == CNT_W'(HDR_W - 1));
    assign last_rise  = sclk_rise && (bit_cnt == CNT_W'(FRAME_W - 1));
    assign extra_rise = sclk_rise && (bit_cnt == CNT_W'(FRAME_W));
    assign active     = (state == HDR) || (state == WDATA) ||
                        (state == RDATA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_sreg   <= '0;
            tx_sreg   <= '0;
            wr_cnt    <= '0;
            spi_miso  <= 1'b0;
            addr      <= '0;
            data_w    <= '0;
            write_vld <= 1'b0;
            read_en   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            read_en   <= 1'b0;
            frame_err <= 1'b0;

            if (write_vld) begin
                if (wr_cnt != '0) begin
                    wr_cnt <= wr_cnt - 1'b1;
                end else begin
                    write_vld <= 1'b0;
                end
            end

            if (read_en) begin
                tx_sreg <= data_r;
            end

            unique case (state)
                IDLE: begin
                    spi_miso <= 1'b0;
                    if (cs_fall) begin
                        state   <= HDR;
                        bit_cnt <= '0;
                    end
                end

                HDR, WDATA, RDATA: begin
                    if (sclk_rise) begin
                        rx_sreg <= rx_next;
                        bit_cnt <= bit_cnt + 1'b1;
                    end

                    // bit 7 appears on the first fall after the load
                    if (state == RDATA && sclk_fall) begin
                        spi_miso <= tx_sreg[DATA_W-1];
                        tx_sreg  <= {tx_sreg[DATA_W-2:0], 1'b0};
                    end

                    if (last_rise) begin
                        state <= WAIT_CS;
                        if (state == WDATA) begin
                            addr      <= frame_addr(rx_next);
                            data_w    <= frame_data(rx_next);
                            write_vld <= 1'b1;
                            wr_cnt    <= PW'(WR_PULSE - 1);
                        end
                    end else if (cs_lvl) begin
                        state    <= IDLE;
                        spi_miso <= 1'b0;
                        if (bit_cnt != '0 || sclk_rise) begin
                            frame_err <= 1'b1;
                        end
                    end else if (state == HDR && hdr_rise) begin
                        if (rx_next[ADDR_W]) begin
                            state   <= RDATA;
                            read_en <= 1'b1;
                            addr    <= rx_next[ADDR_W-1:0];
                        end else begin
                            state <= WDATA;
                        end
                    end
                end

                WAIT_CS: begin
                    spi_miso <= 1'b0;
                    if (extra_rise) begin
                        frame_err <= 1'b1;
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                    if (cs_lvl) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    logic unused_active;
    assign unused_active = active ^ unused_edges;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Randomised self-checking bench for spi_frame_rx against a frame-level model.
// The SPI master runs at clk/16 and drives pins asynchronously to the DUT.
module tb_spi_frame_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_sclk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic [6:0] addr;
    logic [7:0] data_w;
    logic       write_vld;
    logic       read_en;
    logic [7:0] data_r = 8'h00;
    logic       frame_err;

    int checks = 0;
    int failures = 0;

    logic [31:0] miso_cap;

    int          wv_cyc = 0;
    int          wv_n = 0;
    int          re_n = 0;
    int          fe_n = 0;
    logic        wv_prev = 1'b0;
    logic [14:0] wr_log [256];

    always #5 clk = ~clk;

    spi_frame_rx #(.WR_PULSE(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .spi_sclk  (spi_sclk),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .addr      (addr),
        .data_w    (data_w),
        .write_vld (write_vld),
        .read_en   (read_en),
        .data_r    (data_r),
        .frame_err (frame_err)
    );

    always @(negedge clk) begin
        if (write_vld) wv_cyc++;
        if (write_vld && !wv_prev) begin
            wr_log[wv_n % 256] = {addr, data_w};
            wv_n++;
        end
        wv_prev = write_vld;
        if (read_en) re_n++;
        if (frame_err) fe_n++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic spi_xfer(input logic [15:0] frame, input int nbits,
                            input bit cs_with_last, input bit end_cs);
        miso_cap = '0;
        spi_cs_n = 1'b0;
        wait_clk(8);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = (i < 16) ? frame[15-i] : 1'($urandom);
            wait_clk(8);
            miso_cap = {miso_cap[30:0], spi_miso};
            spi_sclk = 1'b1;
            if (cs_with_last && i == nbits - 1) spi_cs_n = 1'b1;
            wait_clk(8);
            spi_sclk = 1'b0;
        end
        if (end_cs) begin
            wait_clk(8);
            spi_cs_n = 1'b1;
            wait_clk(16);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(5);
        checks += 6;
        if (addr !== 7'h00) begin
            failures++;
            $display("FAIL reset_addr got=%h exp=00", addr);
        end
        if (data_w !== 8'h00) begin
            failures++;
            $display("FAIL reset_data got=%h exp=00", data_w);
        end
        if (write_vld !== 1'b0) begin
            failures++;
            $display("FAIL reset_wvld got=%b exp=0", write_vld);
        end
        if (read_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_rden got=%b exp=0", read_en);
        end
        if (frame_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_ferr got=%b exp=0", frame_err);
        end
        if (spi_miso !== 1'b0) begin
            failures++;
            $display("FAIL reset_miso got=%b exp=0", spi_miso);
        end
    endtask

    task automatic test_write_single();
        int w0 = wv_n;
        int c0 = wv_cyc;
        int f0 = fe_n;
        spi_xfer(16'h0105, 16, 1'b0, 1'b1);
        checks += 6;
        if (wv_n - w0 !== 1) begin
            failures++;
            $display("FAIL ws_count got=%0d exp=1", wv_n - w0);
        end
        if (wr_log[w0 % 256] !== {7'h01, 8'h05}) begin
            failures++;
            $display("FAIL ws_log got=%h exp=%h", wr_log[w0 % 256], {7'h01, 8'h05});
        end
        if (wv_cyc - c0 !== 2) begin
            failures++;
            $display("FAIL ws_width got=%0d exp=2", wv_cyc - c0);
        end
        if (addr !== 7'h01) begin
            failures++;
            $display("FAIL ws_addr got=%h exp=01", addr);
        end
        if (data_w !== 8'h05) begin
            failures++;
            $display("FAIL ws_data got=%h exp=05", data_w);
        end
        if (fe_n - f0 !== 0) begin
            failures++;
            $display("FAIL ws_ferr got=%0d exp=0", fe_n - f0);
        end
    endtask

    task automatic test_back_to_back();
        int w0 = wv_n;
        int c0 = wv_cyc;
        int f0 = fe_n;
        spi_xfer(16'h0210, 16, 1'b0, 1'b1);
        spi_xfer(16'h0230, 16, 1'b1, 1'b1);
        checks += 6;
        if (wv_n - w0 !== 2) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=2", wv_n - w0);
        end
        if (wr_log[w0 % 256] !== {7'h02, 8'h10}) begin
            failures++;
            $display("FAIL b2b_first got=%h exp=%h", wr_log[w0 % 256], {7'h02, 8'h10});
        end
        if (wr_log[(w0 + 1) % 256] !== {7'h02, 8'h30}) begin
            failures++;
            $display("FAIL b2b_second got=%h exp=%h", wr_log[(w0 + 1) % 256], {7'h02, 8'h30});
        end
        if (wv_cyc - c0 !== 4) begin
            failures++;
            $display("FAIL b2b_width got=%0d exp=4", wv_cyc - c0);
        end
        if (fe_n - f0 !== 0) begin
            failures++;
            $display("FAIL b2b_ferr got=%0d exp=0", fe_n - f0);
        end
        if ({addr, data_w} !== {7'h02, 8'h30}) begin
            failures++;
            $display("FAIL b2b_regs got=%h exp=%h", {addr, data_w}, {7'h02, 8'h30});
        end
    endtask

    task automatic test_read();
        int w0 = wv_n;
        int r0 = re_n;
        int f0 = fe_n;
        data_r = 8'hA5;
        spi_xfer(16'h8100, 16, 1'b0, 1'b1);
        checks += 7;
        if (re_n - r0 !== 1) begin
            failures++;
            $display("FAIL rd_count got=%0d exp=1", re_n - r0);
        end
        if (miso_cap[7:0] !== 8'hA5) begin
            failures++;
            $display("FAIL rd_miso got=%h exp=a5", miso_cap[7:0]);
        end
        if (miso_cap[15:8] !== 8'h00) begin
            failures++;
            $display("FAIL rd_miso_hdr got=%h exp=00", miso_cap[15:8]);
        end
        if (addr !== 7'h01) begin
            failures++;
            $display("FAIL rd_addr got=%h exp=01", addr);
        end
        if (data_w !== 8'h30) begin
            failures++;
            $display("FAIL rd_data_hold got=%h exp=30", data_w);
        end
        if (wv_n - w0 !== 0 || fe_n - f0 !== 0) begin
            failures++;
            $display("FAIL rd_side got=%0d/%0d exp=0/0", wv_n - w0, fe_n - f0);
        end
        if (spi_miso !== 1'b0) begin
            failures++;
            $display("FAIL rd_miso_idle got=%b exp=0", spi_miso);
        end
    endtask

    task automatic test_abort();
        int w0 = wv_n;
        int f0 = fe_n;
        int f1;
        spi_xfer(16'h0777, 10, 1'b0, 1'b1);
        checks += 4;
        if (wv_n - w0 !== 0) begin
            failures++;
            $display("FAIL ab_wvld got=%0d exp=0", wv_n - w0);
        end
        if (fe_n - f0 !== 1) begin
            failures++;
            $display("FAIL ab_ferr got=%0d exp=1", fe_n - f0);
        end
        if ({addr, data_w} !== {7'h01, 8'h30}) begin
            failures++;
            $display("FAIL ab_regs got=%h exp=%h", {addr, data_w}, {7'h01, 8'h30});
        end
        f1 = fe_n;
        spi_xfer(16'h0000, 0, 1'b0, 1'b1);
        if (fe_n - f1 !== 0) begin
            failures++;
            $display("FAIL ab_empty_ferr got=%0d exp=0", fe_n - f1);
        end
    endtask

    task automatic test_overlong();
        int w0 = wv_n;
        int f0 = fe_n;
        spi_xfer(16'h0342, 18, 1'b0, 1'b1);
        checks += 3;
        if (wv_n - w0 !== 1) begin
            failures++;
            $display("FAIL ol_count got=%0d exp=1", wv_n - w0);
        end
        if (wr_log[w0 % 256] !== {7'h03, 8'h42}) begin
            failures++;
            $display("FAIL ol_log got=%h exp=%h", wr_log[w0 % 256], {7'h03, 8'h42});
        end
        if (fe_n - f0 !== 1) begin
            failures++;
            $display("FAIL ol_ferr got=%0d exp=1", fe_n - f0);
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        int f0;
        spi_xfer(16'h0B77, 12, 1'b0, 1'b0);
        rst = 1'b1;
        spi_cs_n = 1'b1;
        wait_clk(4);
        checks += 3;
        if ({addr, data_w} !== 15'h0) begin
            failures++;
            $display("FAIL rm_regs got=%h exp=0000", {addr, data_w});
        end
        if ({write_vld, read_en, frame_err, spi_miso} !== 4'b0) begin
            failures++;
            $display("FAIL rm_flags got=%b exp=0000", {write_vld, read_en, frame_err, spi_miso});
        end
        rst = 1'b0;
        wait_clk(4);
        w0 = wv_n;
        f0 = fe_n;
        spi_xfer(16'h0C3C, 16, 1'b0, 1'b1);
        if (wv_n - w0 !== 1 || wr_log[w0 % 256] !== {7'h0C, 8'h3C}) begin
            failures++;
            $display("FAIL rm_next got=%0d/%h exp=1/%h", wv_n - w0, wr_log[w0 % 256], {7'h0C, 8'h3C});
        end
        checks++;
        if (fe_n - f0 !== 0) begin
            failures++;
            $display("FAIL rm_ferr got=%0d exp=0", fe_n - f0);
        end
    endtask

    task automatic test_random();
        logic [6:0] exp_addr = 7'h0C;
        logic [7:0] exp_data = 8'h3C;
        for (int k = 0; k < 40; k++) begin
            int          nb = int'($urandom_range(0, 20));
            logic [15:0] f = 16'($urandom);
            logic [7:0]  dr = 8'($urandom);
            int          w0 = wv_n;
            int          r0 = re_n;
            int          f0 = fe_n;
            int          exp_w = (!f[15] && nb >= 16) ? 1 : 0;
            int          exp_r = (f[15] && nb >= 8) ? 1 : 0;
            int          exp_e = ((nb >= 1 && nb <= 15) || nb >= 17) ? 1 : 0;
            logic [7:0]  got_rd;
            data_r = dr;
            spi_xfer(f, nb, 1'($urandom_range(0, 1)), 1'b1);
            if (exp_w == 1) begin
                exp_addr = f[14:8];
                exp_data = f[7:0];
            end
            if (exp_r == 1) exp_addr = f[14:8];
            checks += 4;
            if (wv_n - w0 !== exp_w) begin
                failures++;
                $display("FAIL rnd%0d_wvld got=%0d exp=%0d nb=%0d f=%h", k, wv_n - w0, exp_w, nb, f);
            end
            if (re_n - r0 !== exp_r) begin
                failures++;
                $display("FAIL rnd%0d_rden got=%0d exp=%0d nb=%0d f=%h", k, re_n - r0, exp_r, nb, f);
            end
            if (fe_n - f0 !== exp_e) begin
                failures++;
                $display("FAIL rnd%0d_ferr got=%0d exp=%0d nb=%0d", k, fe_n - f0, exp_e, nb);
            end
            if ({addr, data_w} !== {exp_addr, exp_data}) begin
                failures++;
                $display("FAIL rnd%0d_regs got=%h exp=%h", k, {addr, data_w}, {exp_addr, exp_data});
            end
            if (exp_w == 1) begin
                checks++;
                if (wr_log[w0 % 256] !== {f[14:8], f[7:0]}) begin
                    failures++;
                    $display("FAIL rnd%0d_log got=%h exp=%h", k, wr_log[w0 % 256], f[14:0]);
                end
            end
            if (f[15] && nb >= 16) begin
                got_rd = 8'(miso_cap >> (nb - 16));
                checks++;
                if (got_rd !== dr) begin
                    failures++;
                    $display("FAIL rnd%0d_miso got=%h exp=%h", k, got_rd, dr);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_single();
        test_back_to_back();
        test_read();
        test_abort();
        test_overlong();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
